// File: rtl/dm_store_load.sv
// Word-organised MEM-stage data memory: byte-lane stores (sw/sh/sb), extended loads (lw/lh/lhu/lb/lbu).
// Optional store trace is compiled in with the DM_TRACE_EN macro.
module dm_store_load #(
   parameter int DEPTH_WORDS = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [2:0]  op,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [31:0] pc,
   output logic [31:0] rdata,
   output logic        align_err
);
   localparam int ADDR_W = $clog2(DEPTH_WORDS);

   typedef enum logic [2:0] {
      OP_WORD  = 3'b000,
      OP_HALFU = 3'b001,
      OP_HALFS = 3'b010,
      OP_BYTEU = 3'b011,
      OP_BYTES = 3'b100
   } op_t;

   logic [31:0]       mem [DEPTH_WORDS];
   logic [ADDR_W-1:0] index;
   logic              reserved;
   logic              commit;
   logic [31:0]       cur_word;
   logic [31:0]       lane_data;
   logic [3:0]        byte_en;
   logic [31:0]       merged_word;
   logic [15:0]       half_sel;
   logic [7:0]        byte_sel;

   assign index    = addr[ADDR_W+1:2];
   assign reserved = (op > OP_BYTES);
   assign cur_word = mem[index];

   always_comb begin
      align_err = 1'b0;
      case (op)
         OP_WORD:            align_err = (addr[1:0] != 2'b00);
         OP_HALFU, OP_HALFS: align_err = addr[0];
         default:            align_err = 1'b0;
      endcase
   end

   assign commit = we && !align_err && !reserved;

   // Replicate the narrow store data across all lanes; byte_en picks which lanes land.
   always_comb begin
      lane_data = wdata;
      byte_en   = 4'b0000;
      case (op)
         OP_WORD: begin
            lane_data = wdata;
            byte_en   = 4'b1111;
         end
         OP_HALFU, OP_HALFS: begin
            lane_data = {2{wdata[15:0]}};
            byte_en   = addr[1] ? 4'b1100 : 4'b0011;
         end
         OP_BYTEU, OP_BYTES: begin
            lane_data = {4{wdata[7:0]}};
            byte_en   = 4'b0001 << addr[1:0];
         end
         default: begin
            lane_data = wdata;
            byte_en   = 4'b0000;
         end
      endcase
   end

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign merged_word[8*gi +: 8] = byte_en[gi] ? lane_data[8*gi +: 8] : cur_word[8*gi +: 8];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH_WORDS; i++) begin
            mem[i] <= '0;
         end
      end else if (commit) begin
         mem[index] <= merged_word;
      end
   end

`ifdef DM_TRACE_EN
   always_ff @(posedge clk) begin
      if (!reset && commit) begin
         $display("%0t@%08h: *%08h <= %08h", $time, pc, {addr[31:2], 2'b00}, merged_word);
      end
   end
`else
`endif

   // Loads read the pre-edge array, so a same-cycle store shows up only next cycle.
   assign half_sel = addr[1] ? cur_word[31:16] : cur_word[15:0];
   assign byte_sel = cur_word[8*addr[1:0] +: 8];

   always_comb begin
      rdata = '0;
      if (!align_err) begin
         case (op)
            OP_WORD:  rdata = cur_word;
            OP_HALFU: rdata = {16'h0000, half_sel};
            OP_HALFS: rdata = {{16{half_sel[15]}}, half_sel};
            OP_BYTEU: rdata = {24'h000000, byte_sel};
            OP_BYTES: rdata = {{24{byte_sel[7]}}, byte_sel};
            default:  rdata = '0;
         endcase
      end
   end

   // Address bits above the array and the trace-only pc are intentionally not decoded.
   logic unused_ok;
   assign unused_ok = ^{pc, addr[31:ADDR_W+2]};

endmodule

// File: tb/tb_dm_store_load.sv
// Self-checking bench for dm_store_load: byte-addressed reference model plus literal expectations.
module tb_dm_store_load;
   localparam int DEPTH = 1024;
   localparam int NBYTES = 4 * DEPTH;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        we = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] addr = 32'h0;
   logic [31:0] wdata = 32'h0;
   logic [31:0] pc = 32'h0000_0400;
   logic [31:0] rdata;
   logic        align_err;

   int checks = 0;
   int failures = 0;
   bit cmp_en = 1'b0;

   logic [7:0] mb [NBYTES];

   dm_store_load #(.DEPTH_WORDS(DEPTH)) dut (
      .clk(clk), .reset(reset), .we(we), .op(op), .addr(addr),
      .wdata(wdata), .pc(pc), .rdata(rdata), .align_err(align_err)
   );

   always #5 clk = ~clk;

   // Memory seen as a flat little-endian byte array; width from op, alignment as addr % width.
   function automatic int op_width(input logic [2:0] o);
      if (o == 3'd0) return 4;
      if (o <= 3'd2) return 2;
      return 1;
   endfunction

   function automatic logic [32:0] model_load(input logic [2:0] o, input logic [31:0] a);
      int unsigned b;
      int w;
      logic [31:0] v;
      b = a % NBYTES;
      w = op_width(o);
      v = 32'h0;
      if (o > 3'd4) return 33'h0;
      if ((b % w) != 0) return {1'b1, 32'h0};
      for (int k = 0; k < w; k++) v = v | (32'(mb[b + k]) << (8 * k));
      if (o == 3'd2 && v[15]) v = v | 32'hFFFF_0000;
      if (o == 3'd4 && v[7])  v = v | 32'hFFFF_FF00;
      return {1'b0, v};
   endfunction

   initial begin
      for (int i = 0; i < NBYTES; i++) mb[i] = 8'h00;
   end

   always @(posedge clk) begin
      int unsigned b;
      int w;
      b = addr % NBYTES;
      w = op_width(op);
      if (reset) begin
         for (int i = 0; i < NBYTES; i++) mb[i] = 8'h00;
      end else if (we && op <= 3'd4 && (b % w) == 0) begin
         for (int k = 0; k < w; k++) mb[b + k] = wdata[8*k +: 8];
      end
   end

   always @(negedge clk) begin
      logic [32:0] exp;
      if (cmp_en) begin
         exp = model_load(op, addr);
         checks++;
         if (rdata !== exp[31:0]) begin
            failures++;
            $display("FAIL model_rdata op=%0d addr=%08h got=%08h exp=%08h", op, addr, rdata, exp[31:0]);
         end
         checks++;
         if (align_err !== exp[32]) begin
            failures++;
            $display("FAIL model_align op=%0d addr=%08h got=%0b exp=%0b", op, addr, align_err, exp[32]);
         end
      end
   end

   task automatic step(input logic r, input logic w, input logic [2:0] o,
                       input logic [31:0] a, input logic [31:0] d);
      @(posedge clk);
      #2;
      reset = r; we = w; op = o; addr = a; wdata = d;
      pc = pc + 32'd4;
   endtask

   task automatic lit(input string name, input logic [31:0] exp_rdata, input logic exp_err);
      @(negedge clk);
      #1;
      $display("txn %s: reset=%0b we=%0b op=%0d addr=%08h wdata=%08h rdata=%08h align_err=%0b",
               name, reset, we, op, addr, wdata, rdata, align_err);
      checks++;
      if (rdata !== exp_rdata) begin
         failures++;
         $display("FAIL %s rdata got=%08h exp=%08h", name, rdata, exp_rdata);
      end
      checks++;
      if (align_err !== exp_err) begin
         failures++;
         $display("FAIL %s align_err got=%0b exp=%0b", name, align_err, exp_err);
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      cmp_en = 1'b1;
      step(0, 0, 3'd0, 32'h10, 32'h0);          lit("reset_clear", 32'h0, 1'b0);
      step(0, 1, 3'd0, 32'h10, 32'h12345678);   lit("sw_rdw_pre", 32'h0, 1'b0);
      step(0, 0, 3'd0, 32'h10, 32'h0);          lit("lw_10", 32'h12345678, 1'b0);
      step(0, 1, 3'd3, 32'h11, 32'h000000AB);   lit("sb_11", 32'h00000056, 1'b0);
      step(0, 0, 3'd4, 32'h11, 32'h0);          lit("lb_11", 32'hFFFFFFAB, 1'b0);
      step(0, 0, 3'd3, 32'h11, 32'h0);          lit("lbu_11", 32'h000000AB, 1'b0);
      step(0, 0, 3'd4, 32'h10, 32'h0);          lit("lb_10", 32'h00000078, 1'b0);
      step(0, 0, 3'd0, 32'h10, 32'h0);          lit("lw_merged", 32'h1234AB78, 1'b0);
      step(0, 1, 3'd1, 32'h22, 32'hFFFF8001);   lit("sh_22", 32'h0, 1'b0);
      step(0, 0, 3'd2, 32'h22, 32'h0);          lit("lh_22", 32'hFFFF8001, 1'b0);
      step(0, 0, 3'd1, 32'h22, 32'h0);          lit("lhu_22", 32'h00008001, 1'b0);
      step(0, 0, 3'd2, 32'h20, 32'h0);          lit("lh_20", 32'h0, 1'b0);
      step(0, 0, 3'd0, 32'h20, 32'h0);          lit("lw_20", 32'h80010000, 1'b0);
      step(0, 1, 3'd0, 32'h13, 32'hDEADBEEF);   lit("sw_mis", 32'h0, 1'b1);
      step(0, 0, 3'd0, 32'h10, 32'h0);          lit("lw_after_mis", 32'h1234AB78, 1'b0);
      step(0, 0, 3'd2, 32'h21, 32'h0);          lit("lh_mis", 32'h0, 1'b1);
      step(0, 1, 3'd5, 32'h10, 32'hFFFFFFFF);   lit("st_reserved", 32'h0, 1'b0);
      step(0, 0, 3'd0, 32'h10, 32'h0);          lit("lw_after_rsv", 32'h1234AB78, 1'b0);
      step(0, 1, 3'd0, 32'h10, 32'hCAFEF00D);   lit("sw_rdw_old", 32'h1234AB78, 1'b0);
      step(0, 0, 3'd0, 32'h10, 32'h0);          lit("lw_rdw_new", 32'hCAFEF00D, 1'b0);
      step(0, 0, 3'd0, 32'h10 + 4 * DEPTH, 32'h0); lit("lw_wrap", 32'hCAFEF00D, 1'b0);
      step(0, 1, 3'd4, 32'h13, 32'h00000080);   lit("sb_13", 32'hFFFFFFCA, 1'b0);
      step(0, 0, 3'd4, 32'h13, 32'h0);          lit("lb_13", 32'hFFFFFF80, 1'b0);
      step(0, 0, 3'd0, 32'h10, 32'h0);          lit("lw_lane3", 32'h80FEF00D, 1'b0);
      step(0, 1, 3'd1, 32'h1000 + 32'h32, 32'h0000BEEF); lit("sh_wrap", 32'h0, 1'b0);
      step(0, 0, 3'd0, 32'h30, 32'h0);          lit("lw_30", 32'hBEEF0000, 1'b0);
      // Sweep every op and byte offset over the populated word.
      for (int o = 0; o < 8; o++) begin
         for (int off = 0; off < 4; off++) begin
            step(0, 0, 3'(o), 32'h10 + 32'(off), 32'h0);
         end
      end
      step(1, 1, 3'd0, 32'h0, 32'h11111111);    lit("rst_with_sw", 32'h0, 1'b0);
      step(0, 0, 3'd0, 32'h0, 32'h0);           lit("lw_0_post_rst", 32'h0, 1'b0);
      step(0, 0, 3'd0, 32'h10, 32'h0);          lit("lw_10_post_rst", 32'h0, 1'b0);
      step(0, 0, 3'd0, 32'h20, 32'h0);          lit("lw_20_post_rst", 32'h0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
